// File: rtl/gray_counter_pkg.sv
// rtl/gray_counter_pkg.sv - shared state enum and bin-to-gray helper for the ramp counter
//
// Contents:
//   ramp_state_t   : FSM states IDLE / RUN / DONE
//   GRAY_MAX_WIDTH : widest count supported by bin2gray
//   bin2gray()     : binary to reflected Gray conversion
package gray_counter_pkg;

    localparam int GRAY_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ramp_state_t;

    // Callers zero-extend a WIDTH-bit value to GRAY_MAX_WIDTH and truncate
    // the result back to WIDTH.
    // The upper bits are zero, so the truncated result is the WIDTH-bit Gray code.
    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - single-bit two-flop synchronizer
//
// Ports:
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, clears both flops
//   d       : asynchronous input
//   q       : synchronized output (two clk cycles of latency)
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/gray_ramp_counter.sv
// rtl/gray_ramp_counter.sv - Gray-coded ramp counter with per-column comparator capture
//
// Parameters:
//   WIDTH    : count width in bits (2..GRAY_MAX_WIDTH)
//   CHANNELS : number of comparator capture channels (>= 1)
// Ports:
//   clk        : single rising-edge clock
//   reset_n    : asynchronous active-low reset
//   start      : begin a conversion (accepted in IDLE only)
//   stop       : end the conversion early (honoured in RUN only)
//   max_count  : terminal binary count, sampled on the accepted start
//   saturate   : 1 = stop at max_count, 0 = wrap to 0; sampled on the accepted start
//   cmp        : asynchronous comparator outputs, one per channel
//   count_gray : registered Gray-coded count
//   busy       : high while in RUN
//   done       : one-cycle pulse in DONE
//   cap_data   : captured Gray value, channel i at [i*WIDTH +: WIDTH]
//   hit        : channel captured a comparator edge this conversion
//   overflow   : channel saw no edge before the conversion ended
import gray_counter_pkg::*;

module gray_ramp_counter #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         stop,
    input  logic [WIDTH-1:0]             max_count,
    input  logic                         saturate,
    input  logic [CHANNELS-1:0]          cmp,
    output logic [WIDTH-1:0]             count_gray,
    output logic                         busy,
    output logic                         done,
    output logic [CHANNELS*WIDTH-1:0]    cap_data,
    output logic [CHANNELS-1:0]          hit,
    output logic [CHANNELS-1:0]          overflow
);

    ramp_state_t                       r_state;
    logic [WIDTH-1:0]                  r_bin;
    logic [WIDTH-1:0]                  r_gray;
    logic [WIDTH-1:0]                  r_max;
    logic                              r_sat;
    logic                              r_busy;
    logic                              r_done;
    logic [CHANNELS-1:0][WIDTH-1:0]    r_cap;
    logic [CHANNELS-1:0]               r_hit;
    logic [CHANNELS-1:0]               r_ovf;
    logic [CHANNELS-1:0]               r_cmp_prev;

    logic [CHANNELS-1:0]               w_cmp_sync;
    logic [CHANNELS-1:0]               w_rise;
    logic                              w_at_max;
    logic                              w_end;
    logic [WIDTH-1:0]                  w_bin_next;
    logic [WIDTH-1:0]                  w_gray_next;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
        sync_2ff u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (cmp[g]),
            .q       (w_cmp_sync[g])
        );
    end

    assign w_rise   = w_cmp_sync & ~r_cmp_prev;
    assign w_at_max = (r_bin == r_max);
    // Terminal count only ends the run when saturating; stop and terminal
    // together still make a single transition into DONE.
    assign w_end    = stop | (w_at_max & r_sat);

    // Reaching max_count without saturate wraps back to 0.
    assign w_bin_next  = w_at_max ? '0 : r_bin + WIDTH'(1);
    assign w_gray_next = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(w_bin_next)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_bin      <= '0;
            r_gray     <= '0;
            r_max      <= '0;
            r_sat      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cap      <= '0;
            r_hit      <= '0;
            r_ovf      <= '0;
            r_cmp_prev <= '0;
        end else begin
            r_cmp_prev <= w_cmp_sync;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_bin   <= '0;
                        r_gray  <= '0;
                        r_max   <= max_count;
                        r_sat   <= saturate;
                        r_busy  <= 1'b1;
                        r_cap   <= '0;
                        r_hit   <= '0;
                        r_ovf   <= '0;
                    end
                end

                RUN: begin
                    // First edge wins; the ending cycle still honours a fresh
                    // edge, and every channel still empty takes the held count.
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (!r_hit[i]) begin
                            if (w_rise[i]) begin
                                r_cap[i] <= r_gray;
                                r_hit[i] <= 1'b1;
                            end else if (w_end) begin
                                r_cap[i] <= r_gray;
                                r_ovf[i] <= 1'b1;
                            end
                        end
                    end

                    if (w_end) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_bin   <= w_bin_next;
                        r_gray  <= w_gray_next;
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign count_gray = r_gray;
    assign busy       = r_busy;
    assign done       = r_done;
    assign cap_data   = r_cap;
    assign hit        = r_hit;
    assign overflow   = r_ovf;

endmodule

// File: doc/gray_ramp_counter.md
GRAY_RAMP_COUNTER -- requirements
Module: gray_ramp_counter

Interface
REQ-001 Parameter WIDTH, default 8, count width in bits (min 2).
REQ-002 Parameter CHANNELS, default 4, number of comparator capture channels (min 1).
REQ-003 Port clk  input  1  single clock, all state rising-edge.
REQ-004 Port reset_n  input  1  asynchronous active-low reset.
REQ-005 Port start  input  1  begin conversion (sampled high for one or more cycles).
REQ-006 Port stop  input  1  abort/end conversion early.
REQ-007 Port max_count  input  WIDTH  terminal binary count, sampled on the accepted start.
REQ-008 Port saturate  input  1  1 = stop at max_count; 0 = wrap to 0 and keep running. Sampled on the accepted start.
REQ-009 Port cmp  input  CHANNELS  asynchronous comparator outputs, one per column.
REQ-010 Port count_gray  output  WIDTH  registered Gray-coded count.
REQ-011 Port busy  output  1  high while in RUN.
REQ-012 Port done  output  1  one-cycle pulse at end of conversion.
REQ-013 Port cap_data  output  CHANNELS*WIDTH  per-channel captured Gray value, channel i at bits [i*WIDTH +: WIDTH].
REQ-014 Port hit  output  CHANNELS  channel captured a comparator edge during this conversion.
REQ-015 Port overflow  output  CHANNELS  channel saw no edge before conversion end.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE -> RUN on start.
- RUN -> DONE on stop, or on terminal count when saturate = 1.
- DONE -> IDLE unconditionally after one cycle.
REQ-017 On the edge accepting start, the block SHALL clear the internal binary count to 0 and count_gray to 0, and SHALL clear hit and overflow.
REQ-018 In RUN, the binary count SHALL increment by 1 per clock.
- count_gray SHALL equal bin ^ (bin >> 1) of the same cycle's binary count.
- count_gray SHALL be registered and change exactly one bit per increment.
REQ-019 When bin == max_count in RUN with saturate = 1, the next edge SHALL enter DONE and hold count_gray.
- With saturate = 0, the next edge SHALL wrap bin to 0 and remain in RUN.
REQ-020 max_count = 0 with saturate = 1 SHALL give exactly one RUN cycle at count 0.
REQ-021 busy SHALL be high in RUN only; done SHALL be high in DONE only.
REQ-022 Each cmp bit SHALL pass through a two-flop synchronizer followed by rising-edge detect.
- A detected edge in RUN with hit[i] = 0 SHALL load cap_data[i] with that cycle's count_gray and set hit[i].
- Later edges in the same conversion SHALL be ignored.
REQ-023 Edges detected in IDLE or DONE SHALL be ignored.
REQ-024 On entry to DONE, every channel with hit[i] = 0 SHALL set overflow[i] and load cap_data[i] with the held count_gray.
REQ-025 start while in RUN or DONE SHALL be ignored; stop in IDLE or DONE SHALL be ignored.
REQ-026 stop and terminal count in the same RUN cycle SHALL produce a single DONE.
REQ-027 A channel edge detected in the cycle that stop is sampled SHALL still be captured as hit.
REQ-028 cap_data, hit and overflow SHALL hold their values from DONE until the next accepted start.

Reset
REQ-029 reset_n low SHALL asynchronously force all of the following to 0 at any time, including mid-conversion:
- state = IDLE
- bin and count_gray
- busy and done
- cap_data, hit and overflow
- all synchronizer flops
REQ-030 After reset_n deassertion, the block SHALL accept start no earlier than the first clk edge.

Structure
REQ-031 A shared package gray_counter_pkg SHALL hold the FSM state enum (IDLE/RUN/DONE) and a bin-to-gray function parametrised by WIDTH.
REQ-032 The synchronizer SHALL be one sub-module, sync_2ff (1-bit, clk, reset_n), instantiated CHANNELS times.

Verification (WIDTH = 8, CHANNELS = 4)
REQ-033 Saturate run: max_count = 10, saturate = 1, start pulse at edge 0.
- count_gray after edges 0..10 SHALL be 0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15.
- done SHALL be high after edge 11; busy SHALL be low after edge 12.
REQ-034 Wrap run: max_count = 3, saturate = 0.
- count_gray SHALL be 0, 1, 3, 2, 0, 1, ... until stop, then done for one cycle.
- The wrap SHALL not pulse done.
REQ-035 Capture: max_count = 20, cmp[1] rises when count = 5 and cmp[2] rises when count = 9; cmp[0] and cmp[3] stay low.
- Required response: hit = 4'b0110; cap_data[1] = gray(7) = 4, cap_data[2] = gray(11) = 14.
- The +2 is synchronizer latency.
- overflow = 4'b1001, with cap_data[0] = cap_data[3] = gray(20) = 30.
REQ-036 Early stop at count 6: done one cycle later and count_gray holds 5; a second cmp[1] edge is ignored; start asserted during RUN has no effect.
REQ-037 Reset mid-run: reset_n low at count 7 immediately zeros all outputs without a clock; a fresh start after release restarts at 0.
